// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR tap-coefficient BRAM access path.
package fir_pkg;

    localparam int NUM_TAPS     = 11;
    localparam int ADDR_WIDTH   = 12;
    localparam int DATA_WIDTH   = 32;
    localparam int STARVE_MAX   = 4;
    localparam int STARVE_WIDTH = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CFG  = 2'd1,
        TAG_ENG  = 2'd2,
        TAG_OOR  = 2'd3
    } tag_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr < ADDR_WIDTH'(NUM_TAPS));
    endfunction

endpackage

// File: rtl/tap_bram_arbiter_if.sv
// Request/grant/read-return bundle for the cfg (AXI-Lite) and FIR engine requesters.
interface tap_bram_arbiter_if;
    import fir_pkg::*;

    logic                  cfg_req;
    logic                  cfg_we;
    logic [ADDR_WIDTH-1:0] cfg_addr;
    logic [DATA_WIDTH-1:0] cfg_wdata;
    logic                  cfg_gnt;
    logic                  cfg_rvalid;
    logic [DATA_WIDTH-1:0] cfg_rdata;

    logic                  eng_busy;
    logic                  eng_req;
    logic [ADDR_WIDTH-1:0] eng_addr;
    logic                  eng_gnt;
    logic                  eng_rvalid;
    logic [DATA_WIDTH-1:0] eng_rdata;

    modport master (
        output cfg_req, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_gnt, cfg_rvalid, cfg_rdata,
        output eng_busy, eng_req, eng_addr,
        input  eng_gnt, eng_rvalid, eng_rdata
    );

    modport slave (
        input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
        output cfg_gnt, cfg_rvalid, cfg_rdata,
        input  eng_busy, eng_req, eng_addr,
        output eng_gnt, eng_rvalid, eng_rdata
    );

endinterface

// File: rtl/tap_bram_arbiter.sv
// Single-port tap BRAM arbiter: engine-priority arbitration with cfg anti-starvation,
// hardware tap clear, and tag-based routing of registered read data.
module tap_bram_arbiter
    import fir_pkg::*;
(
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    tap_bram_arbiter_if.slave     bus,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  tap_WE,
    output logic                  tap_EN,
    output logic [ADDR_WIDTH-1:0] tap_A,
    output logic [DATA_WIDTH-1:0] tap_Di,
    input  logic [DATA_WIDTH-1:0] tap_Do
);

    localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR  = ADDR_WIDTH'(NUM_TAPS - 1);
    localparam logic [STARVE_WIDTH-1:0] STARVE_LIM = STARVE_WIDTH'(STARVE_MAX);

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   clr_addr_r;
    logic [ADDR_WIDTH-1:0]   clr_addr_nxt_s;
    logic [STARVE_WIDTH-1:0] starve_r;
    logic [STARVE_WIDTH-1:0] starve_nxt_s;
    tag_e                    tag_r;
    tag_e                    tag_nxt_s;
    logic                    tag_eng_r;
    logic                    tag_eng_nxt_s;
    logic                    cfg_ok_s;
    logic                    cfg_in_range_s;
    logic                    eng_in_range_s;

    // State, clear pointer, starvation counter and read tag registers
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_r    <= S_IDLE;
            clr_addr_r <= '0;
            starve_r   <= '0;
            tag_r      <= TAG_NONE;
            tag_eng_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            clr_addr_r <= clr_addr_nxt_s;
            starve_r   <= starve_nxt_s;
            tag_r      <= tag_nxt_s;
            tag_eng_r  <= tag_eng_nxt_s;
        end
    end

    // Arbitration, BRAM port drive and next-state; everything held at 0 while in reset
    always_comb begin
        state_nxt_s    = state_r;
        clr_addr_nxt_s = clr_addr_r;
        starve_nxt_s   = starve_r;
        tag_nxt_s      = TAG_NONE;
        tag_eng_nxt_s  = 1'b0;
        bus.cfg_gnt    = 1'b0;
        bus.eng_gnt    = 1'b0;
        clr_busy       = 1'b0;
        tap_WE         = 1'b0;
        tap_EN         = 1'b0;
        tap_A          = '0;
        tap_Di         = '0;
        // A cfg write must never land while the engine is streaming taps
        cfg_ok_s       = bus.cfg_req && !(bus.cfg_we && bus.eng_busy);
        cfg_in_range_s = addr_in_range(bus.cfg_addr);
        eng_in_range_s = addr_in_range(bus.eng_addr);
        if (!axis_rst_n) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cfg_ok_s && (starve_r == STARVE_LIM)) begin
                        bus.cfg_gnt = 1'b1;
                    end else if (bus.eng_req) begin
                        bus.eng_gnt = 1'b1;
                    end else if (cfg_ok_s) begin
                        bus.cfg_gnt = 1'b1;
                    end else begin
                        bus.cfg_gnt = 1'b0;
                    end

                    if (bus.cfg_gnt) begin
                        tap_A  = bus.cfg_addr;
                        tap_EN = cfg_in_range_s;
                        tap_WE = bus.cfg_we && cfg_in_range_s;
                        tap_Di = bus.cfg_we ? bus.cfg_wdata : '0;
                        if (!bus.cfg_we) begin
                            tag_nxt_s = cfg_in_range_s ? TAG_CFG : TAG_OOR;
                        end else begin
                            tag_nxt_s = TAG_NONE;
                        end
                    end else if (bus.eng_gnt) begin
                        tap_A         = bus.eng_addr;
                        tap_EN        = eng_in_range_s;
                        tag_nxt_s     = eng_in_range_s ? TAG_ENG : TAG_OOR;
                        tag_eng_nxt_s = 1'b1;
                    end else begin
                        tag_nxt_s = TAG_NONE;
                    end

                    if (!bus.cfg_req || bus.cfg_gnt) begin
                        starve_nxt_s = '0;
                    end else if (cfg_ok_s && (starve_r != STARVE_LIM)) begin
                        starve_nxt_s = starve_r + STARVE_WIDTH'(1);
                    end else begin
                        starve_nxt_s = starve_r;
                    end

                    if (clr_start && !bus.cfg_gnt && !bus.eng_gnt) begin
                        state_nxt_s    = S_CLEAR;
                        clr_addr_nxt_s = '0;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    clr_busy = 1'b1;
                    tap_WE   = 1'b1;
                    tap_EN   = 1'b1;
                    tap_A    = clr_addr_r;
                    if (clr_addr_r == LAST_ADDR) begin
                        state_nxt_s    = S_IDLE;
                        clr_addr_nxt_s = '0;
                    end else begin
                        clr_addr_nxt_s = clr_addr_r + ADDR_WIDTH'(1);
                    end
                    if (!bus.cfg_req) begin
                        starve_nxt_s = '0;
                    end else begin
                        starve_nxt_s = starve_r;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // Route the BRAM's registered read data to the requester captured in the tag
    always_comb begin
        bus.cfg_rvalid = 1'b0;
        bus.cfg_rdata  = '0;
        bus.eng_rvalid = 1'b0;
        bus.eng_rdata  = '0;
        case (tag_r)
            TAG_CFG: begin
                bus.cfg_rvalid = 1'b1;
                bus.cfg_rdata  = tap_Do;
            end
            TAG_ENG: begin
                bus.eng_rvalid = 1'b1;
                bus.eng_rdata  = tap_Do;
            end
            TAG_OOR: begin
                if (tag_eng_r) begin
                    bus.eng_rvalid = 1'b1;
                end else begin
                    bus.cfg_rvalid = 1'b1;
                end
            end
            TAG_NONE: begin
                bus.cfg_rvalid = 1'b0;
            end
            default: begin
                bus.cfg_rvalid = 1'b0;
            end
        endcase
    end

endmodule
